axi_lite_master: RTL
====================

// Module: axi_lite_master
// PURPOSE
// - AXI4-Lite initiator: converts a single-beat core-side request (load/store from IFU/LSU) into
//   AR/R or AW/W/B transactions toward an AXI4-Lite responder (UART, SRAM, CLINT via xbar).
// - One outstanding transaction at a time; tolerates arbitrary responder delays and independent AW/W acceptance.
// PARAMETERS
// - ADDR_W  32  address width of req_addr / araddr / awaddr
// - DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
// - clk           in   1         clock, all state updates on rising edge
// - rst           in   1         asynchronous, active-high reset
// - req_valid     in   1         core request valid
// - req_ready     out  1         request accepted this cycle (req_valid & req_ready = fire)
// - req_wen       in   1         1 = write, 0 = read
// - req_addr      in   ADDR_W   byte address, passed unchanged (no alignment check)
// - req_wdata     in   DATA_W   write data
// - req_wstrb     in   DATA_W/8 write byte strobes
// - resp_valid    out  1         response valid, held until resp_ready
// - resp_ready    in   1         core accepts response
// - resp_rdata    out  DATA_W   read data (0 for writes)
// - resp_err      out  1         1 when rresp/bresp != OKAY
// - araddr/arvalid/arready, rdata/rresp/rvalid/rready, awaddr/awvalid/awready,
//   wdata/wstrb/wvalid/wready, bresp/bvalid/bready: standard AXI4-Lite master side, widths per ADDR_W/DATA_W
// BEHAVIOUR
// - Reset (async): state IDLE; arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err = 0;
//   resp_rdata, address/data output registers = 0. All AXI valids drop immediately, mid-transfer included.
// - FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
// - IDLE: req_ready = 1 (combinational from state). On fire latch addr/data/strb; read -> RD_ADDR, write -> WR_REQ.
//   All other states: req_ready = 0.
// - RD_ADDR: arvalid = 1, araddr stable until arvalid & arready; then -> RD_DATA. arvalid rises cycle after req fire.
// - RD_DATA: rready = 1; on rvalid & rready capture rdata, err = (rresp != OKAY) -> RESP.
// - WR_REQ: awvalid and wvalid both asserted on entry; each deasserts independently the cycle after its
//   own handshake (AW and W fire same or different cycles, either order). When both have fired -> WR_RESP.
//   AXI-compliant: valids never wait on ready; once asserted, held with stable payload until fire.
// - WR_RESP: bready = 1; on bvalid & bready err = (bresp != OKAY), resp_rdata = 0 -> RESP.
// - RESP: resp_valid = 1, resp_rdata/resp_err stable; on resp_ready -> IDLE. Earliest next req fire is the cycle after.
// - Minimum latency with zero-delay responder: read req fire at T -> resp_valid at T+3; write likewise T+3.
// - rready/bready asserted only in RD_DATA/WR_RESP; early rvalid/bvalid in other states is ignored (held by responder).
// - rresp/bresp decode: 2'b00 OKAY, 2'b01 EXOKAY treated as OKAY, 2'b10/2'b11 -> resp_err = 1; data still returned.
// - req_* inputs ignored outside IDLE; changes after fire do not affect the in-flight transaction.
// STRUCTURE
// - Shared package axi_lite_pkg: resp codes (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR),
//   master FSM state enum, default ADDR_W/DATA_W constants; reused by responders (UART, SRAM).
// - Single module, no sub-module: one FSM, aw_done/w_done flags, payload/response registers.
// TESTING
// - Read, responder arready after 3 cycles, rvalid 2 cycles later with rdata=32'hDEADBEEF, rresp=00
//   -> araddr stable throughout, resp_valid with rdata=DEADBEEF, resp_err=0.
// - Write addr=32'hA00003F8, wdata=32'h41, wstrb=4'h1; awready at T+1, wready at T+4
//   -> awvalid drops after T+1, wvalid held to T+4, single bready handshake, resp_err=0.
// - Write with wready before awready, bresp=2'b10 -> both handshakes complete once, resp_valid with resp_err=1.
// - resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, new req_valid not accepted.
// - Assert rst in RD_DATA with rvalid pending -> arvalid/rready/resp_valid 0 in same cycle, req_ready=1 after release.
// - Back-to-back read then write with zero-delay responder, resp_ready=1 -> each resp 3 cycles after fire, no overlap.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and
// default bus widths. Responders (UART, SRAM) import this package too.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } master_state_e;

    // EXOKAY is treated as success; SLVERR and DECERR are errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with initiator (master) and responder (slave) views.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) ();

    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns one core load/store request into an AR/R or
// AW/W/B exchange, one transaction in flight, and returns a held response.
// All AXI valid/ready outputs are decoded from registered state, so they
// never depend combinationally on responder inputs.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,

    axi_lite_if.master          axi
);

    localparam int STRB_W = DATA_W / 8;

    master_state_e       state_q,   state_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic                err_q,     err_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q,  w_done_d;

    // State, latched payload and captured response; async clear drops every valid at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;

        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Latch the request so later changes on req_* cannot leak in.
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? WR_REQ : RD_ADDR;
                end
            end

            RD_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    err_d   = resp_is_err(axi.rresp);
                    state_d = RESP;
                end
            end

            WR_REQ: begin
                // AW and W are tracked separately: each valid stays up until
                // its own handshake and then drops, in whichever order they land.
                axi.awvalid = !aw_done_q;
                axi.wvalid  = !w_done_q;
                aw_done_d   = aw_done_q || axi.awready;
                w_done_d    = w_done_q  || axi.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    rdata_d = '0;
                    err_d   = resp_is_err(axi.bresp);
                    state_d = RESP;
                end
            end

            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address and write payload are held in registers for the whole transfer.
    assign axi.araddr = addr_q;
    assign axi.awaddr = addr_q;
    assign axi.wdata  = wdata_q;
    assign axi.wstrb  = wstrb_q;

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
